// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and parity helper.
// The future uart_rx is expected to import this package as well.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Data narrower than 9 bits arrives zero-extended, so the extra zeros do not disturb the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input parity_t mode);
    logic p;
    p = ^data;
    return (mode == PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the head entry while not empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO; every bit is paced by the shared baudtick strobe.
// A new frame is popped on the final stop-bit tick so queued frames go out with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PARITY_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          baudtick,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be PARITY_NONE, PARITY_EVEN or PARITY_ODD");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
  end

  localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 parity_bit;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 line_val;

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  // A pop is only possible from IDLE or on the last stop-bit tick.
  assign fifo_pop = !reset && baudtick && !fifo_empty &&
                    ((state == IDLE) || (state == STOP && stop_cnt == LAST_STOP));

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    line_val = 1'b1;
    case (state)
      START:            line_val = 1'b0;
      DATA:             line_val = shreg[0];
      uart_pkg::PARITY: line_val = parity_bit;
      default:          line_val = 1'b1;
    endcase
  end

  // tx registers the line value of the current state, so it trails each state change by one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
    end else begin
      tx <= line_val;
      if (baudtick) begin
        case (state)
          IDLE: begin
            if (fifo_pop) begin
              shreg      <= fifo_rdata;
              parity_bit <= calc_parity(9'(fifo_rdata), PARITY);
              state      <= START;
            end
          end
          START: begin
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              stop_cnt <= 1'b0;
              state    <= HAS_PARITY ? uart_pkg::PARITY : STOP;
            end
          end
          uart_pkg::PARITY: begin
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
          STOP: begin
            if (stop_cnt != LAST_STOP) begin
              stop_cnt <= 1'b1;
            end else if (fifo_pop) begin
              shreg      <= fifo_rdata;
              parity_bit <= calc_parity(9'(fifo_rdata), PARITY);
              state      <= START;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
